// File: rtl/alu_md.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_md : handshaked RV32I/M execution unit, iterative multiply and divide |
// | Revision 1.0                                                              |
// +-----------------------------------------------------------------------------+
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_0,
  input  logic [XLEN-1:0] in_1,
  input  logic [4:0]      operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero,
  output logic            busy
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_XOR    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_AND    = 5'd4;
  localparam logic [4:0] OP_SRL    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_PASS_1 = 5'd8;
  localparam logic [4:0] OP_SLT    = 5'd9;
  localparam logic [4:0] OP_SLTU   = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   out_q;
  logic              zero_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic [CW-1:0]     cnt;
  logic              is_div_q, sel_hi_q, neg_q;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base;
  logic              is_m, is_dv, div_zero, div_ovf, iter, accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;

  assign shamt    = in_1[SHW-1:0];
  assign is_m     = (operation[4:3] == 2'b10);
  assign is_dv    = is_m & operation[2];
  assign div_zero = (in_1 == '0);
  assign div_ovf  = is_dv & ~operation[0] & (in_0 == SMIN) & (&in_1);
  assign iter     = is_m & ~(is_dv & (div_zero | div_ovf));
  assign accept   = in_valid & in_ready;

  assign a_signed = (operation == OP_MULH) | (operation == OP_MULHSU) | (is_dv & ~operation[0]);
  assign b_signed = (operation == OP_MULH) | (is_dv & ~operation[0]);
  assign a_neg    = a_signed & in_0[XLEN-1];
  assign b_neg    = b_signed & in_1[XLEN-1];
  assign mag_a    = a_neg ? -in_0 : in_0;
  assign mag_b    = b_neg ? -in_1 : in_1;

  // Single-cycle results, including the divide-by-zero and overflow fast paths.
  always_comb begin
    base = '0;
    case (operation)
      OP_ADD:    base = in_0 + in_1;
      OP_SUB:    base = in_0 - in_1;
      OP_XOR:    base = in_0 ^ in_1;
      OP_OR:     base = in_0 | in_1;
      OP_AND:    base = in_0 & in_1;
      OP_SRL:    base = in_0 >> shamt;
      OP_SLL:    base = in_0 << shamt;
      OP_SRA:    base = $unsigned($signed(in_0) >>> shamt);
      OP_PASS_1: base = in_1;
      OP_SLT:    base = {{(XLEN-1){1'b0}}, $signed(in_0) < $signed(in_1)};
      OP_SLTU:   base = {{(XLEN-1){1'b0}}, in_0 < in_1};
      OP_DIV, OP_DIVU: base = div_zero ? '1 : in_0;
      OP_REM, OP_REMU: base = div_zero ? in_0 : '0;
      default:   base = '0;
    endcase
  end

  // acc holds {high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   rem_sub, div_pick;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, mul_full;
  logic [XLEN-1:0]   fin;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_nx  = {mul_sum, acc[XLEN-1:1]};
  assign rem_sh  = acc[2*XLEN-1:XLEN-1];
  assign div_ge  = (rem_sh >= {1'b0, mcand});
  assign rem_sub = rem_sh[XLEN-1:0] - mcand;
  assign div_nx  = {div_ge ? rem_sub : rem_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
  assign acc_nx  = is_div_q ? div_nx : mul_nx;

  always_comb begin
    mul_full = neg_q ? -acc_nx : acc_nx;
    div_pick = sel_hi_q ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    if (is_div_q) fin = neg_q ? -div_pick : div_pick;
    else          fin = sel_hi_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (cnt == CNT_ONE) state_nx = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nx = in_valid ? (iter ? S_BUSY : S_DONE) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_q    <= '0;
      zero_q   <= 1'b1;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (iter) begin
          acc      <= {{XLEN{1'b0}}, is_dv ? mag_a : mag_b};
          mcand    <= is_dv ? mag_b : mag_a;
          cnt      <= CNT_INIT;
          is_div_q <= is_dv;
          sel_hi_q <= is_dv ? operation[1] : (operation[1:0] != 2'b00);
          neg_q    <= (is_dv & operation[1]) ? a_neg : (a_neg ^ b_neg);
        end else begin
          out_q  <= base;
          zero_q <= (base == '0);
        end
      end else if (state == S_BUSY) begin
        acc <= acc_nx;
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          out_q  <= fin;
          zero_q <= (fin == '0);
        end
      end
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);

endmodule
`default_nettype wire
